// File: rtl/turn_scheduler.sv
// Turn scheduler for the two-player game core.
// Runs the per-turn countdown and alternates the active player.
// Grants the shared board datapath to the active player through a
// request/grant/done handshake, and detects win, draw and timeout.
// Every output is a register that changes only on the clock edge that
// performs the matching state transition (or asynchronously on rst).
module turn_scheduler #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TURN_SECS     = 15,
    parameter int MAX_MOVES     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       req_p1,
    input  logic       req_p2,
    input  logic       move_done,
    input  logic       win,
    output logic       grant_p1,
    output logic       grant_p2,
    output logic       turn,
    output logic [5:0] secs_left,
    output logic       finished,
    output logic [5:0] move_count,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]    SECS_INIT = 6'(TURN_SECS);
    localparam logic [5:0]    MOVES_MAX = 6'(MAX_MOVES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN   = 3'd1,
        APPLY  = 3'd2,
        CHECK  = 3'd3,
        SWITCH = 3'd4,
        OVER   = 3'd5
    } state_t;

    state_t        state_reg, state_next;
    logic          turn_reg, turn_next;
    logic [5:0]    secs_reg, secs_next;
    logic [PW-1:0] pre_reg, pre_next;
    logic          finished_reg, finished_next;
    logic [5:0]    moves_reg, moves_next;
    logic [1:0]    winner_reg, winner_next;
    logic          over_reg, over_next;
    logic [1:0]    grant_reg, grant_next;

    logic          tick;
    logic          active_req;

    // Only the active player's request can start a move.
    assign active_req = turn_reg ? req_p2 : req_p1;
    assign tick       = (pre_reg == PRE_MAX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath and output registers, all updated from the next-state logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn_reg     <= 1'b0;
            secs_reg     <= 6'd0;
            pre_reg      <= '0;
            finished_reg <= 1'b0;
            moves_reg    <= 6'd0;
            winner_reg   <= 2'b00;
            over_reg     <= 1'b0;
            grant_reg    <= 2'b00;
        end else begin
            turn_reg     <= turn_next;
            secs_reg     <= secs_next;
            pre_reg      <= pre_next;
            finished_reg <= finished_next;
            moves_reg    <= moves_next;
            winner_reg   <= winner_next;
            over_reg     <= over_next;
            grant_reg    <= grant_next;
        end
    end

    // Next-state logic and next values for every registered output.
    always_comb begin
        state_next    = state_reg;
        turn_next     = turn_reg;
        secs_next     = secs_reg;
        pre_next      = pre_reg;
        finished_next = 1'b0;
        moves_next    = moves_reg;
        winner_next   = winner_reg;

        case (state_reg)
            IDLE, OVER: begin
                if (start) begin
                    state_next  = TURN;
                    turn_next   = 1'b0;
                    secs_next   = SECS_INIT;
                    pre_next    = '0;
                    moves_next  = 6'd0;
                    winner_next = 2'b00;
                end
            end
            TURN: begin
                if (active_req) begin
                    // Request beats a simultaneous timeout; timer freezes.
                    state_next = APPLY;
                end else begin
                    pre_next = tick ? '0 : pre_reg + PW'(1);
                    if (tick) begin
                        if (secs_reg == 6'd1) begin
                            secs_next     = 6'd0;
                            finished_next = 1'b1;
                            state_next    = SWITCH;
                        end else if (secs_reg != 6'd0) begin
                            secs_next = secs_reg - 6'd1;
                        end
                    end
                end
            end
            APPLY: begin
                if (move_done) begin
                    moves_next = (moves_reg == 6'd63) ? 6'd63 : moves_reg + 6'd1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (win) begin
                    state_next  = OVER;
                    // turn + 1: P1 (turn 0) -> 01, P2 (turn 1) -> 10.
                    winner_next = {turn_reg, ~turn_reg};
                end else if (moves_reg == MOVES_MAX) begin
                    state_next  = OVER;
                    winner_next = 2'b11;
                end else begin
                    state_next = SWITCH;
                end
            end
            SWITCH: begin
                state_next = TURN;
                turn_next  = ~turn_reg;
                secs_next  = SECS_INIT;
                pre_next   = '0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign over_next = (state_next == OVER);

    // One grant per player: high for the whole stay in APPLY, owner only.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            localparam logic OWNER = (gi == 1);
            assign grant_next[gi] = (state_next == APPLY) && (turn_next == OWNER);
        end
    endgenerate

    assign grant_p1   = grant_reg[0];
    assign grant_p2   = grant_reg[1];
    assign turn       = turn_reg;
    assign secs_left  = secs_reg;
    assign finished   = finished_reg;
    assign move_count = moves_reg;
    assign game_over  = over_reg;
    assign winner     = winner_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler with TICKS_PER_SEC=4,
// TURN_SECS=3, MAX_MOVES=4. Expected output snapshots are queued as
// stimulus is driven and compared after the following clock edge.
module tb_turn_scheduler;

    logic       clk;
    logic       rst;
    logic       start;
    logic       req_p1;
    logic       req_p2;
    logic       move_done;
    logic       win;
    logic       grant_p1;
    logic       grant_p2;
    logic       turn;
    logic [5:0] secs_left;
    logic       finished;
    logic [5:0] move_count;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state;

    int checks;
    int errors;

    typedef struct {
        string       tag;
        logic [21:0] vec;
    } exp_t;

    exp_t sb[$];

    turn_scheduler #(
        .TICKS_PER_SEC(4),
        .TURN_SECS    (3),
        .MAX_MOVES    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .req_p1    (req_p1),
        .req_p2    (req_p2),
        .move_done (move_done),
        .win       (win),
        .grant_p1  (grant_p1),
        .grant_p2  (grant_p2),
        .turn      (turn),
        .secs_left (secs_left),
        .finished  (finished),
        .move_count(move_count),
        .game_over (game_over),
        .winner    (winner),
        .state     (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed outputs, packed in the same order as pk().
    logic [21:0] obs;
    assign obs = {state, turn, secs_left, finished, move_count,
                  game_over, winner, grant_p1, grant_p2};

    function automatic logic [21:0] pk(input logic [2:0] st, input logic t,
                                       input logic [5:0] s, input logic f,
                                       input logic [5:0] m, input logic ov,
                                       input logic [1:0] w, input logic g1,
                                       input logic g2);
        return {st, t, s, f, m, ov, w, g1, g2};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Queue an expectation, run one clock, compare after the edge.
    task automatic step(input string tag, input logic [21:0] exp);
        exp_t e;
        sb.push_back('{tag, exp});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val(e.tag, {10'd0, obs}, {10'd0, e.vec});
        $display("step %-12s state=%0d turn=%0d secs=%0d fin=%0d moves=%0d over=%0d win=%0d g=%0d%0d",
                 e.tag, state, turn, secs_left, finished, move_count,
                 game_over, winner, grant_p1, grant_p2);
    endtask

    // Compare without waiting for a clock (asynchronous reset).
    task automatic now(input string tag, input logic [21:0] exp);
        exp_t e;
        sb.push_back('{tag, exp});
        e = sb.pop_front();
        check_val(e.tag, {10'd0, obs}, {10'd0, e.vec});
        $display("now  %-12s state=%0d outputs=%h", e.tag, state, obs);
    endtask

    // One complete move by player t starting with m moves already made.
    // The inactive player's request is held high too and must be ignored.
    task automatic do_move(input logic t, input int m, input logic w);
        req_p1 = 1'b1;
        req_p2 = 1'b1;
        step("grant", pk(3'd2, t, 6'd3, 1'b0, 6'(m), 1'b0, 2'd0, ~t, t));
        req_p1    = 1'b0;
        req_p2    = 1'b0;
        move_done = 1'b1;
        step("check", pk(3'd3, t, 6'd3, 1'b0, 6'(m + 1), 1'b0, 2'd0, 1'b0, 1'b0));
        move_done = 1'b0;
        win       = w;
        if (w) begin
            step("win", pk(3'd5, t, 6'd3, 1'b0, 6'(m + 1), 1'b1,
                           t ? 2'd2 : 2'd1, 1'b0, 1'b0));
        end else if (m + 1 == 4) begin
            step("draw", pk(3'd5, t, 6'd3, 1'b0, 6'd4, 1'b1, 2'd3, 1'b0, 1'b0));
        end else begin
            step("switch", pk(3'd4, t, 6'd3, 1'b0, 6'(m + 1), 1'b0, 2'd0, 1'b0, 1'b0));
            win = 1'b0;
            step("next_turn", pk(3'd1, ~t, 6'd3, 1'b0, 6'(m + 1), 1'b0, 2'd0, 1'b0, 1'b0));
        end
        win = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        req_p1    = 1'b0;
        req_p2    = 1'b0;
        move_done = 1'b0;
        win       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        now("reset", 22'd0);
        rst = 1'b0;
        step("idle", 22'd0);

        // Reset mid-move: reach APPLY with grant_p1, then pulse rst.
        start = 1'b1;
        step("start", pk(3'd1, 1'b0, 6'd3, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        start  = 1'b0;
        req_p1 = 1'b1;
        step("req_p1", pk(3'd2, 1'b0, 6'd3, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 1'b0));
        rst = 1'b1;
        #2;
        now("rst_async", 22'd0);
        #1;
        rst    = 1'b0;
        req_p1 = 1'b0;
        step("idle_again", 22'd0);
        start = 1'b1;
        step("restart", pk(3'd1, 1'b0, 6'd3, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        start = 1'b0;

        // Turn timeout with all requests low.
        for (int k = 1; k <= 11; k++) begin
            step("countdown", pk(3'd1, 1'b0, 6'(3 - k / 4), 1'b0, 6'd0, 1'b0,
                                 2'd0, 1'b0, 1'b0));
        end
        step("timeout", pk(3'd4, 1'b0, 6'd0, 1'b1, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        step("to_p2", pk(3'd1, 1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));

        // P2's turn: req_p1 and start are ignored.
        req_p1 = 1'b1;
        start  = 1'b1;
        step("ignore_p1", pk(3'd1, 1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        step("ignore_p1b", pk(3'd1, 1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        start  = 1'b0;
        req_p1 = 1'b0;

        // Normal P2 move; win is ignored while in APPLY.
        req_p2 = 1'b1;
        step("grant_p2", pk(3'd2, 1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b1));
        win = 1'b1;
        step("apply_hold", pk(3'd2, 1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b1));
        win       = 1'b0;
        req_p2    = 1'b0;
        move_done = 1'b1;
        step("check_p2", pk(3'd3, 1'b1, 6'd3, 1'b0, 6'd1, 1'b0, 2'd0, 1'b0, 1'b0));
        move_done = 1'b0;
        step("switch_p2", pk(3'd4, 1'b1, 6'd3, 1'b0, 6'd1, 1'b0, 2'd0, 1'b0, 1'b0));
        step("turn_p1", pk(3'd1, 1'b0, 6'd3, 1'b0, 6'd1, 1'b0, 2'd0, 1'b0, 1'b0));

        // Draw: three more moves reach MAX_MOVES = 4.
        do_move(1'b0, 1, 1'b0);
        do_move(1'b1, 2, 1'b0);
        do_move(1'b0, 3, 1'b0);
        move_done = 1'b1;
        req_p1    = 1'b1;
        step("over_hold", pk(3'd5, 1'b0, 6'd3, 1'b0, 6'd4, 1'b1, 2'd3, 1'b0, 1'b0));
        move_done = 1'b0;
        req_p1    = 1'b0;
        start     = 1'b1;
        step("new_game", pk(3'd1, 1'b0, 6'd3, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        start = 1'b0;

        // Win by P2 on the second move.
        do_move(1'b0, 0, 1'b0);
        do_move(1'b1, 1, 1'b1);
        start = 1'b1;
        step("after_win", pk(3'd1, 1'b0, 6'd3, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0));
        start = 1'b0;

        // Request in the same cycle as the third tick beats the timeout.
        for (int k = 1; k <= 11; k++) begin
            step("count2", pk(3'd1, 1'b0, 6'(3 - k / 4), 1'b0, 6'd0, 1'b0,
                              2'd0, 1'b0, 1'b0));
        end
        req_p1 = 1'b1;
        step("req_wins", pk(3'd2, 1'b0, 6'd1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 1'b0));
        req_p1 = 1'b0;
        step("frozen", pk(3'd2, 1'b0, 6'd1, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 1'b0));
        move_done = 1'b1;
        step("check_late", pk(3'd3, 1'b0, 6'd1, 1'b0, 6'd1, 1'b0, 2'd0, 1'b0, 1'b0));
        move_done = 1'b0;

        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
